// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweep checker.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SAMPLE,
        FINISH
    } state_t;

    localparam int DEF_N_IN   = 4;
    localparam int DEF_SETTLE = 2;

    // Number of input patterns swept, which is also the truth-table width.
    function automatic int n_patterns(input int n_in);
        return 1 << n_in;
    endfunction

    // fail_count needs one extra bit so that "every pattern failed" fits.
    function automatic int fc_width(input int n_in);
        return n_in + 1;
    endfunction

    // The hold counter is loaded with SETTLE-1, so it never needs to hold SETTLE.
    function automatic int cnt_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter with a zero flag; paces the per-pattern hold time.
module tt_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tt_sweep_checker.sv
// Drives every input pattern onto a truth-table gate, captures its response
// and compares the assembled table against a latched golden table.
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int N_IN      = DEF_N_IN,
    parameter int SETTLE    = DEF_SETTLE,
    parameter int SYNC_RESP = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [n_patterns(N_IN)-1:0] expected_tt,
    output logic [N_IN-1:0]             stim,
    input  logic                        resp,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [n_patterns(N_IN)-1:0] tt_obs,
    output logic [fc_width(N_IN)-1:0]   fail_count,
    output logic [N_IN-1:0]             first_fail_idx
);

    localparam int TT_W  = n_patterns(N_IN);
    localparam int FC_W  = fc_width(N_IN);
    localparam int CNT_W = cnt_width(SETTLE);

    localparam logic [N_IN-1:0]  LAST_PAT  = N_IN'(TT_W - 1);
    localparam logic [FC_W-1:0]  FC_MAX    = FC_W'(TT_W);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam state_t           AFTER_LOAD = (SETTLE == 0) ? SAMPLE : HOLD;

    state_t            state;
    state_t            state_nxt;
    logic [TT_W-1:0]   exp_q;
    logic              sample;
    logic              timer_load;
    logic              timer_en;
    logic              timer_zero;
    logic              accept;
    logic              capture;
    logic              last_pat;
    logic              mismatch;
    logic [N_IN-1:0]   bit_idx;
    logic [FC_W-1:0]   fc_next;

    // Optional two-flop synchronizer on the gate response.
    generate
        if (SYNC_RESP != 0) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[0], resp};
                end
            end
            assign sample = sync_q[1];
        end else begin : g_direct
            assign sample = resp;
        end
    endgenerate

    tt_settle_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (HOLD_LOAD),
        .en       (timer_en),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    timer_load = 1'b1;
                    state_nxt  = AFTER_LOAD;
                end
            end
            HOLD: begin
                if (timer_zero) begin
                    state_nxt = SAMPLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            SAMPLE: begin
                if (stim == LAST_PAT) begin
                    state_nxt = FINISH;
                end else begin
                    timer_load = 1'b1;
                    state_nxt  = AFTER_LOAD;
                end
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Table is MSB-first: pattern p lands at bit TT_W-1-p, which is ~p.
    assign bit_idx  = ~stim;
    assign accept   = (state == IDLE) && start;
    assign capture  = (state == SAMPLE);
    assign last_pat = (stim == LAST_PAT);
    assign mismatch = sample ^ exp_q[bit_idx];
    assign fc_next  = (mismatch && (fail_count != FC_MAX)) ? fail_count + FC_W'(1) : fail_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q          <= '0;
            stim           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            tt_obs         <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                exp_q          <= expected_tt;
                tt_obs         <= '0;
                fail_count     <= '0;
                first_fail_idx <= '0;
                pass           <= 1'b0;
                stim           <= '0;
                busy           <= 1'b1;
            end
            if (capture) begin
                tt_obs[bit_idx] <= sample;
                fail_count      <= fc_next;
                if (mismatch && (fail_count == '0)) begin
                    first_fail_idx <= stim;
                end
                // The last pattern stays on stim; it only wraps on the next accept.
                if (last_pat) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= (fc_next == '0);
                end else begin
                    stim <= stim + N_IN'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Randomized and directed bench for tt_sweep_checker against a pattern-level model.
module tb_tt_sweep_checker;

    localparam int SETTLE_A = 2;
    localparam int TIMEOUT  = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start_a = 1'b0;
    logic [15:0] exp_a   = '0;
    logic [15:0] gate_a  = '0;
    logic [3:0]  stim_a;
    logic        resp_a;
    logic        busy_a, done_a, pass_a;
    logic [15:0] tt_a;
    logic [4:0]  fc_a;
    logic [3:0]  ffi_a;

    logic        start_b = 1'b0;
    logic [15:0] exp_b   = '0;
    logic [3:0]  stim_b;
    logic        busy_b, done_b, pass_b;
    logic [15:0] tt_b;
    logic [4:0]  fc_b;
    logic [3:0]  ffi_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Gate under test: output for pattern p is table bit 15-p.
    function automatic logic gate_out(input logic [15:0] tt, input int p);
        return tt[15 - p];
    endfunction

    assign resp_a = gate_out(gate_a, int'(stim_a));

    tt_sweep_checker #(.N_IN(4), .SETTLE(SETTLE_A), .SYNC_RESP(0)) u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .start          (start_a),
        .expected_tt    (exp_a),
        .stim           (stim_a),
        .resp           (resp_a),
        .busy           (busy_a),
        .done           (done_a),
        .pass           (pass_a),
        .tt_obs         (tt_a),
        .fail_count     (fc_a),
        .first_fail_idx (ffi_a)
    );

    tt_sweep_checker #(.N_IN(4), .SETTLE(0), .SYNC_RESP(0)) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .start          (start_b),
        .expected_tt    (exp_b),
        .stim           (stim_b),
        .resp           (1'b1),
        .busy           (busy_b),
        .done           (done_b),
        .pass           (pass_b),
        .tt_obs         (tt_b),
        .fail_count     (fc_b),
        .first_fail_idx (ffi_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: walk the patterns in order and score each against the golden bit.
    function automatic void model(input logic [15:0] gate, input logic [15:0] golden,
                                  output logic [15:0] obs, output int fc,
                                  output int ffi, output bit ok);
        obs = '0;
        fc  = 0;
        ffi = 0;
        for (int p = 0; p < 16; p++) begin
            logic r;
            r = gate_out(gate, p);
            obs[15 - p] = r;
            if (r != golden[15 - p]) begin
                if (fc == 0) ffi = p;
                fc++;
            end
        end
        ok = (fc == 0);
    endfunction

    // Start a sweep on DUT A and follow it until done (or an injected reset).
    task automatic run_a(input logic [15:0] gate, input logic [15:0] golden,
                         input int start_poke, input int exp_poke, input int rst_at,
                         output int lat);
        bit finished;
        int pat;
        finished = 0;
        gate_a  = gate;
        exp_a   = golden;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        lat = 0;
        check("busy_on_accept", busy_a, 1);
        check("stim_on_accept", stim_a, 0);
        while (!finished && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
            start_a = (lat == start_poke);
            if (lat == exp_poke) exp_a = '0;
            if (lat == rst_at) begin
                rst = 1'b1;
                #2;
                rst = 1'b0;
                finished = 1;
            end else if (done_a) begin
                finished = 1;
            end else begin
                pat = lat / (SETTLE_A + 1);
                check("stim_hold", stim_a, (pat > 15) ? 15 : pat);
                check("busy_mid", busy_a, 1);
            end
        end
        start_a = 1'b0;
        if (!finished) check("sweep_timeout", 0, 1);
    endtask

    task automatic verify_a(input string tag, input logic [15:0] gate,
                            input logic [15:0] golden, input int lat);
        logic [15:0] obs;
        int fc, ffi;
        bit ok;
        model(gate, golden, obs, fc, ffi, ok);
        check({tag, "_latency"}, lat, 16 * (SETTLE_A + 1));
        check({tag, "_tt_obs"}, tt_a, obs);
        check({tag, "_pass"}, pass_a, ok);
        check({tag, "_fail_count"}, fc_a, fc);
        check({tag, "_first_fail"}, ffi_a, ffi);
        check({tag, "_busy_done"}, busy_a, 0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done_a, 0);
        check({tag, "_pass_hold"}, pass_a, ok);
    endtask

    task automatic quiet_a(input string tag, input int cycles);
        int extra_done;
        int extra_busy;
        extra_done = 0;
        extra_busy = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done_a) extra_done++;
            if (busy_a) extra_busy++;
        end
        check({tag, "_no_done"}, extra_done, 0);
        check({tag, "_no_busy"}, extra_busy, 0);
    endtask

    initial begin
        int lat;
        logic [15:0] g, e, m;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_stim", stim_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_tt_obs", tt_a, 0);
        check("rst_fail_count", fc_a, 0);
        check("rst_first_fail", ffi_a, 0);

        run_a(16'hBC16, 16'hBC16, -1, -1, -1, lat);
        verify_a("golden", 16'hBC16, 16'hBC16, lat);

        // Asynchronous reset in idle, checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("async_rst_tt_obs", tt_a, 0);
        check("async_rst_pass", pass_a, 0);
        check("async_rst_stim", stim_a, 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        run_a(16'hBC16, 16'hBC17, -1, -1, -1, lat);
        verify_a("mis_lsb", 16'hBC16, 16'hBC17, lat);
        check("mis_lsb_idx_direct", ffi_a, 15);
        run_a(16'hBC16, 16'h3C16, -1, -1, -1, lat);
        verify_a("mis_msb", 16'hBC16, 16'h3C16, lat);
        run_a(16'hBC16, ~16'hBC16, -1, -1, -1, lat);
        verify_a("all_fail", 16'hBC16, ~16'hBC16, lat);
        check("all_fail_saturate", fc_a, 16);

        run_a(16'hBC16, 16'hBC16, 10, 12, -1, lat);
        verify_a("ignore", 16'hBC16, 16'hBC16, lat);
        quiet_a("ignore", 60);

        run_a(16'hBC16, 16'hBC16, -1, -1, 20, lat);
        check("midrst_busy", busy_a, 0);
        check("midrst_stim", stim_a, 0);
        check("midrst_tt_obs", tt_a, 0);
        check("midrst_done", done_a, 0);
        quiet_a("midrst", 60);
        run_a(16'hBC16, 16'hBC16, -1, -1, -1, lat);
        verify_a("after_rst", 16'hBC16, 16'hBC16, lat);

        for (int it = 0; it < 16; it++) begin
            g = 16'($urandom);
            case (it % 3)
                0: m = '0;
                1: m = 16'(1) << $urandom_range(15, 0);
                default: m = 16'($urandom);
            endcase
            e = g ^ m;
            run_a(g, e, -1, -1, -1, lat);
            verify_a("random", g, e, lat);
        end

        // SETTLE=0 instance with resp tied high; start held to exercise re-arm.
        exp_b   = 16'hFFFF;
        start_b = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        check("s0_stim_accept", stim_b, 0);
        while (!done_b && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
            check("s0_stim_step", stim_b, (lat > 15) ? 15 : lat);
        end
        check("s0_latency", lat, 16);
        check("s0_pass", pass_b, 1);
        check("s0_tt_obs", tt_b, 16'hFFFF);
        @(posedge clk); #1;
        check("s0_finish_to_idle", busy_b, 0);
        @(posedge clk); #1;
        check("s0_rearm", busy_b, 1);
        start_b = 1'b0;
        lat = 0;
        while (!done_b && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
        check("s0_rearm_latency", lat, 16);
        @(posedge clk); #1;

        exp_b   = 16'h7FFF;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        lat = 0;
        while (!done_b && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
        check("s0_mis_latency", lat, 16);
        check("s0_mis_pass", pass_b, 0);
        check("s0_mis_fail_count", fc_b, 1);
        check("s0_mis_first_fail", ffi_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
